// File: rtl/uart_port_ctrl_pkg.sv
// uart_port_ctrl_pkg: COM1 access engine state encoding and request decode helper.
package uart_port_ctrl_pkg;
  typedef enum logic [2:0] {
    UART_IDLE,
    UART_RD_LOW,
    UART_WR_SETUP,
    UART_WR_LOW,
    UART_WR_TBRE,
    UART_WR_TSRE,
    UART_DONE
  } uart_state_e;
  function automatic uart_state_e accept_state(input logic cmd, input logic we, input logic re);
    return cmd ? UART_DONE : we ? UART_WR_SETUP : re ? UART_RD_LOW : UART_DONE;
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer, async reset to 0 (clk, rst, d async in, q synced out).
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: COM1 data/command access engine driving UART rdn/wrn over the shared Ram1 bus (req/addr_cmd/we/re/wdata in, rdata/done/busy/err out, bus_out/bus_oe/bus_in bus, rdn/wrn strobes, tbre/tsre/data_ready async status).
module uart_port_ctrl
  import uart_port_ctrl_pkg::*;
#(
  parameter int          RD_LOW_CYCLES = 2,
  parameter int          WR_LOW_CYCLES = 2,
  parameter logic [15:0] TX_TIMEOUT    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        addr_cmd,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic [15:0] bus_in,
  output logic        rdn,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);
  logic tbre_s, tsre_s, data_ready_s;
  uart_sync u_tbre (.clk(clk), .rst(rst), .d(tbre), .q(tbre_s));
  uart_sync u_tsre (.clk(clk), .rst(rst), .d(tsre), .q(tsre_s));
  uart_sync u_dr (.clk(clk), .rst(rst), .d(data_ready), .q(data_ready_s));
  uart_state_e state, next;
  logic [15:0] cnt, rdata_d, bus_out_d;
  logic last_rd, last_wr, tmo, rdn_d, wrn_d, oe_d, done_d, busy_d, err_d, cmd_rd;
  logic unused_hi;
  assign unused_hi = ^{wdata[15:8], bus_in[15:8]};
  assign last_rd = cnt == 16'(RD_LOW_CYCLES - 1);
  assign last_wr = cnt == 16'(WR_LOW_CYCLES - 1);
  assign tmo = cnt == TX_TIMEOUT - 16'd1;
  assign cmd_rd = state == UART_IDLE && req && addr_cmd && re && !we;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= UART_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      UART_IDLE:     if (req) next = accept_state(addr_cmd, we, re);
      UART_RD_LOW:   if (last_rd) next = UART_DONE;
      UART_WR_SETUP: next = UART_WR_LOW;
      UART_WR_LOW:   if (last_wr) next = UART_WR_TBRE;
      UART_WR_TBRE:  next = tbre_s ? UART_WR_TSRE : tmo ? UART_DONE : UART_WR_TBRE;
      UART_WR_TSRE:  next = (tsre_s || tmo) ? UART_DONE : UART_WR_TSRE;
      default:       next = UART_IDLE;
    endcase
  end
  // Outputs are registered from the next state so strobes change on the same edge as the state.
  always_comb begin
    rdn_d = next != UART_RD_LOW;
    wrn_d = next != UART_WR_LOW;
    oe_d = next == UART_WR_SETUP || next == UART_WR_LOW;
    done_d = next == UART_DONE;
    busy_d = next != UART_IDLE;
    err_d = next == UART_DONE && (state == UART_WR_TBRE || (state == UART_WR_TSRE && !tsre_s));
    rdata_d = cmd_rd ? {14'b0, data_ready_s, tbre_s & tsre_s}
            : (state == UART_RD_LOW && last_rd) ? {8'h00, bus_in[7:0]} : rdata;
    bus_out_d = (state == UART_IDLE && next == UART_WR_SETUP) ? {8'h00, wdata[7:0]} : bus_out;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdn <= 1'b1;
      wrn <= 1'b1;
      bus_oe <= 1'b0;
      bus_out <= '0;
      rdata <= '0;
      done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
    end else begin
      rdn <= rdn_d;
      wrn <= wrn_d;
      bus_oe <= oe_d;
      bus_out <= bus_out_d;
      rdata <= rdata_d;
      done <= done_d;
      busy <= busy_d;
      err <= err_d;
      cnt <= (next != state || state == UART_IDLE) ? '0 : cnt + 16'd1;
    end
endmodule

// File: tb/tb_uart_port_ctrl.sv
// tb_uart_port_ctrl: vector table, hand sequences and randomized transactions against a latency/result model.
module tb_uart_port_ctrl;
  localparam int RDL = 2, WRL = 2, TMO = 16;
  logic clk = 0, rst = 1, req = 0, addr_cmd = 0, we = 0, re = 0;
  logic tbre = 0, tsre = 0, data_ready = 0;
  logic [15:0] wdata = 0, bus_in = 0;
  logic [15:0] rdata, bus_out;
  logic done, busy, err, bus_oe, rdn, wrn;
  always #5 clk = ~clk;
  uart_port_ctrl #(.RD_LOW_CYCLES(RDL), .WR_LOW_CYCLES(WRL), .TX_TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst(rst), .req(req), .addr_cmd(addr_cmd), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err), .bus_out(bus_out), .bus_oe(bus_oe),
    .bus_in(bus_in), .rdn(rdn), .wrn(wrn), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );
  typedef struct {
    logic [2:0]  op;
    logic [15:0] wdata;
    logic [15:0] bus_in;
    logic [2:0]  st;
    int          lat;
    logic [15:0] rdata;
    logic        err;
    int          rl;
    int          wl;
  } vec_t;
  int total = 0, bad = 0;
  logic [15:0] prev = 0;
  vec_t tbl[11];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v, input logic [15:0] p);
    vec_t m = v;
    logic cmd = v.op[2], w = v.op[1], r = v.op[0];
    logic tb = v.st[2], ts = v.st[1], dr = v.st[0];
    logic wr = !cmd && w, rd = !cmd && !w && r;
    m.rl = rd ? RDL : 0;
    m.wl = wr ? WRL : 0;
    m.err = wr && !(tb && ts);
    m.rdata = (cmd && r && !w) ? {14'b0, dr, tb & ts} : rd ? {8'h00, v.bus_in[7:0]} : p;
    m.lat = rd ? RDL + 1 : !wr ? 1 : !tb ? 2 + WRL + TMO : !ts ? 3 + WRL + TMO : 4 + WRL;
    return m;
  endfunction
  // mode 1: a second req pulse mid-access; mode 2: tbre/tsre rise 5/9 clocks after wrn rises
  task automatic run(input vec_t e, input int mode, input string tag);
    int cyc = 0, rl = 0, wl = 0, viol = 0, dones = 0, rise = 0;
    logic pw = 1, seen = 0;
    {addr_cmd, we, re} = e.op;
    {tbre, tsre, data_ready} = e.st;
    wdata = e.wdata;
    bus_in = e.bus_in;
    repeat (3) @(negedge clk);
    req = 1;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rdn) rl++;
      if (!wrn) wl++;
      if ((!rdn && !wrn) || (bus_oe && !rdn) || !busy || (err && !done)) viol++;
      if (!wrn && (!bus_oe || bus_out !== {8'h00, e.wdata[7:0]})) viol++;
      if (mode == 1) req = cyc != 2;
      if (mode == 2) begin
        if (!pw && wrn) rise = cyc;
        if (rise > 0 && cyc == rise + 5) tbre = 1;
        if (rise > 0 && cyc == rise + 9) tsre = 1;
      end
      pw = wrn;
      if (done) seen = 1;
    end
    req = 0;
    check({tag, " latency"}, cyc, e.lat);
    check({tag, " rdata"}, rdata, e.rdata);
    check({tag, " err"}, err, e.err);
    check({tag, " rdn_lows"}, rl, e.rl);
    check({tag, " wrn_lows"}, wl, e.wl);
    check({tag, " protocol"}, viol, 0);
    check({tag, " done_bus"}, {rdn, wrn, bus_oe}, 3'b110);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done || busy || err) dones++;
    end
    check({tag, " after_done"}, dones, 0);
    prev = e.rdata;
  endtask
  initial begin
    vec_t v;
    int n;
    tbl[0]  = '{3'b101, 16'h0000, 16'h0000, 3'b110, 1, 16'h0001, 1'b0, 0, 0};
    tbl[1]  = '{3'b001, 16'h0000, 16'hAB5A, 3'b110, 3, 16'h005A, 1'b0, 2, 0};
    tbl[2]  = '{3'b101, 16'h0000, 16'h0000, 3'b101, 1, 16'h0002, 1'b0, 0, 0};
    tbl[3]  = '{3'b000, 16'h5555, 16'h0077, 3'b111, 1, 16'h0002, 1'b0, 0, 0};
    tbl[4]  = '{3'b110, 16'h00C3, 16'h0000, 3'b110, 1, 16'h0002, 1'b0, 0, 0};
    tbl[5]  = '{3'b010, 16'h1241, 16'h0000, 3'b110, 6, 16'h0002, 1'b0, 0, 2};
    tbl[6]  = '{3'b010, 16'h00A5, 16'h0000, 3'b010, 20, 16'h0002, 1'b1, 0, 2};
    tbl[7]  = '{3'b010, 16'hFF3C, 16'h0000, 3'b100, 21, 16'h0002, 1'b1, 0, 2};
    tbl[8]  = '{3'b011, 16'h7E81, 16'h1234, 3'b110, 6, 16'h0002, 1'b0, 0, 2};
    tbl[9]  = '{3'b001, 16'h0000, 16'h12FF, 3'b111, 3, 16'h00FF, 1'b0, 2, 0};
    tbl[10] = '{3'b101, 16'h0000, 16'h0000, 3'b111, 1, 16'h0003, 1'b0, 0, 0};
    repeat (2) @(negedge clk);
    check("reset_outputs", {rdn, wrn, bus_oe, bus_out, rdata, done, busy, err}, {3'b110, 32'h0, 3'b000});
    rst = 0;
    for (int i = 0; i < 11; i++) run(tbl[i], i == 8 ? 1 : 0, $sformatf("vec%0d", i));
    run('{3'b010, 16'h1241, 16'h0000, 3'b000, 16, 16'h0003, 1'b0, 0, 2}, 2, "late_tx");
    check("late_tx bus_out", bus_out, 16'h0041);
    {addr_cmd, we, re} = 3'b010;
    {tbre, tsre} = 2'b11;
    wdata = 16'h0099;
    @(negedge clk);
    req = 1;
    n = 0;
    while (wrn && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_reach_wr_low", wrn, 1'b0);
    @(negedge clk);
    rst = 1;
    #1;
    check("rst_async", {wrn, bus_oe, busy}, 3'b100);
    req = 0;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("rst_no_done", n, 0);
    @(negedge clk);
    rst = 0;
    prev = 0;
    run(tbl[0], 0, "post_rst");
    for (int i = 0; i < 40; i++) begin
      v.op = 3'($urandom);
      v.wdata = 16'($urandom);
      v.bus_in = 16'($urandom);
      v.st = ($urandom_range(0, 3) == 0) ? 3'($urandom) : {2'b11, 1'($urandom)};
      run(model(v, prev), 0, $sformatf("rnd%0d", i));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
